uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Memory-mapped bus master that feeds the UART component's transmit path from an internal byte FIFO.
- Producers push bytes with a valid/ready handshake. The block polls the UART control register (address 0) for TX busy and writes each byte to the Tx buffer (address 2) only while TX is idle.
- It sits between CPU or firmware-less producers (e.g. a debug/trace stream) and the UART chip-select bus port.
- It never writes the UART control register.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2 to 256.
- TX_BUSY_BIT, 1, bit index of the TX-busy flag in the UART control register.
- HOLDOFF, 2, idle cycles after a Tx write before the next poll, so busy becomes visible; 1 to 15.
- TIMEOUT, 4096, max cycles busy may stay set (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  producer byte valid
- s_data  in  8  producer byte
- s_ready  out  1  FIFO not full
- uart_cs  out  1  UART chip select, active low
- uart_rd  out  1  UART read strobe, active low
- uart_wr  out  1  UART write strobe, active low
- uart_addr  out  3  UART register address
- uart_wdata  out  8  data to UART in_data
- uart_rdata  in  8  UART out_data; combinational, valid in the same cycle as rd low
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- idle  out  1  FIFO empty and FSM in S_IDLE
- timeout_err  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async assert, sync release):
  - uart_cs, uart_rd and uart_wr are 1; uart_addr=0; uart_wdata=0.
  - FIFO pointers and level are 0; s_ready=1; idle=1; timeout_err=0; FSM is S_IDLE.
- Reset mid-transaction: strobes deassert immediately (asynchronously) and FIFO contents are discarded.
- FIFO push: s_valid & s_ready in a cycle writes s_data.
  - Push while full is ignored (s_ready=0).
  - Simultaneous push and pop keeps level unchanged, including at level 0? No: pop requires non-empty, so at level 0 only the push takes effect.
  - Pointers wrap modulo DEPTH.
  - level=DEPTH means s_ready=0.
- All bus outputs are registered. Exactly one of rd/wr is low per access, and cs is low only during an access.
- FSM:
  - S_IDLE: if FIFO not empty, go to S_POLL.
  - S_POLL (1 cycle): cs=0, rd=0, addr=0. Register uart_rdata[TX_BUSY_BIT] into busy_q at the end of the cycle. Go to S_CHECK.
  - S_CHECK: cs and rd are 1.
    - If busy_q=1, go to S_POLL. Back-to-back polls are separated by one S_CHECK cycle.
    - Otherwise go to S_WRITE.
  - S_WRITE (1 cycle): cs=0, wr=0, addr=2, wdata=FIFO head. Pop the FIFO in this cycle, load the holdoff counter with HOLDOFF, and go to S_HOLD.
  - S_HOLD: strobes inactive; decrement the counter. At 0, go to S_POLL if the FIFO is non-empty, else S_IDLE.
- Minimum byte period is 4+HOLDOFF cycles plus UART busy time.
- Bytes are sent in push order. No byte is lost or duplicated.
- Reading address 0 clears nothing in the UART; the sequencer never reads address 1.
- If the FIFO is pushed during S_HOLD, S_HOLD still runs its full count.
- Empty FIFO in S_IDLE: no bus activity at all.

Optional Feature:
- Macro: UART_TX_SEQ_TIMEOUT_EN.
- When defined:
  - A counter increments on every S_CHECK where busy_q=1 and clears on a write.
  - When it reaches TIMEOUT, timeout_err is set (sticky until reset), the FIFO is flushed (level→0) and the FSM returns to S_IDLE.
  - Bytes pushed afterwards are sequenced normally.
- When undefined: no counter; the FSM polls indefinitely; timeout_err is constant 0.

Test Plan:
- Reset, then push 0x41: one poll with busy=0, then a write cycle with addr=2, wdata=0x41. cs/wr low exactly 1 cycle; idle=1 after HOLDOFF.
- Model busy=1 for 100 cycles, push 0x55: repeated polls (rd low every 2nd cycle), no wr until busy=0, then a single write of 0x55.
- Push 16 bytes 0x00..0x0F with DEPTH=16 and UART held busy: s_ready=0 and level=16; a 17th push is ignored. Release busy: exactly 16 writes in order 0x00..0x0F.
- Assert reset during S_WRITE with level=5: strobes go high in the same cycle, level=0, no further bus activity after release.
- Push and drain simultaneously at level=3: level stays 3 across the push+pop cycle, and the write order is preserved.
- With UART_TX_SEQ_TIMEOUT_EN and TIMEOUT=64, busy stuck at 1, push 3 bytes: timeout_err=1 after 64 busy polls, level=0, idle=1. After busy clears, a new push of 0x7E is written normally.

Source files
------------

// File: rtl/uart_tx_sequencer_if.sv
// Producer byte stream plus UART chip-select bus, seen from the sequencer.
// master: sequencer side; slave: producer/UART side.
interface uart_tx_sequencer_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       uart_cs;
   logic       uart_rd;
   logic       uart_wr;
   logic [2:0] uart_addr;
   logic [7:0] uart_wdata;
   logic [7:0] uart_rdata;

   modport master (
      input  s_valid, s_data, uart_rdata,
      output s_ready, uart_cs, uart_rd, uart_wr,
      output uart_addr, uart_wdata
   );

   modport slave (
      output s_valid, s_data, uart_rdata,
      input  s_ready, uart_cs, uart_rd, uart_wr,
      input  uart_addr, uart_wdata
   );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Drains a byte FIFO into the UART Tx buffer, polling TX busy before each write.
// Stuck-busy timeout and flush are built only with UART_TX_SEQ_TIMEOUT_EN.
module uart_tx_sequencer #(
   parameter int DEPTH       = 16,
   parameter int TX_BUSY_BIT = 1,
   parameter int HOLDOFF     = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic                   clock,
   input  logic                   reset,
   uart_tx_sequencer_if.master    bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   idle,
   output logic                   timeout_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_CHECK, S_WRITE, S_HOLD
   } state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          busy_q;
   logic [3:0]    hcnt;
   logic          push;
   logic          pop;
   logic          flush;

   assign push        = bus.s_valid && bus.s_ready;
   assign pop         = (state == S_WRITE);
   assign bus.s_ready = (count != (AW+1)'(DEPTH));
   assign level       = count;
   assign idle        = (count == '0) && (state == S_IDLE);

`ifdef UART_TX_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          terr;
   assign flush = (state == S_CHECK) && busy_q
                  && (tcnt == TW'(TIMEOUT - 1));
   assign timeout_err = terr;
`else
   assign flush       = 1'b0;
   assign timeout_err = (TIMEOUT < 0);
`endif

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= bus.s_data;
   end

   // A flush keeps a byte pushed in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= (AW+1)'(push);
         end else begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
               count <= count + (AW+1)'(1);
            else if (pop && !push)
               count <= count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         busy_q         <= 1'b0;
         hcnt           <= '0;
         bus.uart_cs    <= 1'b1;
         bus.uart_rd    <= 1'b1;
         bus.uart_wr    <= 1'b1;
         bus.uart_addr  <= '0;
         bus.uart_wdata <= '0;
`ifdef UART_TX_SEQ_TIMEOUT_EN
         tcnt           <= '0;
         terr           <= 1'b0;
`endif
      end else begin
         bus.uart_cs <= 1'b1;
         bus.uart_rd <= 1'b1;
         bus.uart_wr <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (count != '0) begin
                  state         <= S_POLL;
                  bus.uart_cs   <= 1'b0;
                  bus.uart_rd   <= 1'b0;
                  bus.uart_addr <= 3'd0;
               end
            end
            S_POLL: begin
               busy_q <= bus.uart_rdata[TX_BUSY_BIT];
               state  <= S_CHECK;
            end
            S_CHECK: begin
               if (busy_q) begin
`ifdef UART_TX_SEQ_TIMEOUT_EN
                  if (tcnt == TW'(TIMEOUT - 1)) begin
                     terr  <= 1'b1;
                     tcnt  <= '0;
                     state <= S_IDLE;
                  end else begin
                     tcnt          <= tcnt + TW'(1);
                     state         <= S_POLL;
                     bus.uart_cs   <= 1'b0;
                     bus.uart_rd   <= 1'b0;
                     bus.uart_addr <= 3'd0;
                  end
`else
                  state         <= S_POLL;
                  bus.uart_cs   <= 1'b0;
                  bus.uart_rd   <= 1'b0;
                  bus.uart_addr <= 3'd0;
`endif
               end else begin
                  state          <= S_WRITE;
                  bus.uart_cs    <= 1'b0;
                  bus.uart_wr    <= 1'b0;
                  bus.uart_addr  <= 3'd2;
                  bus.uart_wdata <= mem[rd_ptr];
               end
            end
            S_WRITE: begin
               hcnt  <= 4'(HOLDOFF);
               state <= S_HOLD;
`ifdef UART_TX_SEQ_TIMEOUT_EN
               tcnt  <= '0;
`endif
            end
            S_HOLD: begin
               if (hcnt != 4'd0) begin
                  hcnt <= hcnt - 4'd1;
               end else if (count != '0) begin
                  state         <= S_POLL;
                  bus.uart_cs   <= 1'b0;
                  bus.uart_rd   <= 1'b0;
                  bus.uart_addr <= 3'd0;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a one-bit TX-busy UART model.
// Bus activity is logged on falling edges and compared to hand-computed values.
module tb_uart_tx_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       busy  = 1'b0;
   logic [4:0] level;
   logic       idle;
   logic       timeout_err;

   int         checks = 0;
   int         errors = 0;
   int         polls  = 0;
   int         viol   = 0;
   int         p0;
   logic [7:0] wq[$];
   bit         prev_wr = 1'b0;
   bit         prev_rd = 1'b0;

   always #5 clock = ~clock;

   uart_tx_sequencer_if bus();

   assign bus.uart_rdata =
      (!bus.uart_cs && !bus.uart_rd && bus.uart_addr == 3'd0)
      ? {6'd0, busy, 1'b0} : 8'h00;

   uart_tx_sequencer #(
      .DEPTH(16), .TX_BUSY_BIT(1), .HOLDOFF(2), .TIMEOUT(64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .level(level),
      .idle(idle),
      .timeout_err(timeout_err)
   );

   always @(negedge clock) begin
      if (reset) begin
         if (!bus.uart_cs && !bus.uart_wr) wq.push_back(bus.uart_wdata);
         if (!bus.uart_cs && !bus.uart_rd) polls++;
         if (bus.uart_cs != (bus.uart_rd && bus.uart_wr)) viol++;
         if (!bus.uart_rd && !bus.uart_wr) viol++;
         if (!bus.uart_wr && (bus.uart_addr != 3'd2 || prev_wr)) viol++;
         if (!bus.uart_rd && (bus.uart_addr != 3'd0 || prev_rd)) viol++;
         prev_wr = !bus.uart_wr;
         prev_rd = !bus.uart_rd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      @(negedge clock);
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_wr(input int lim);
      int n = 0;
      while (bus.uart_wr !== 1'b0 && n < lim) begin
         @(negedge clock);
         n++;
      end
      chk("wr_seen", 32'(bus.uart_wr === 1'b0), 1);
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (idle !== 1'b1 && n < lim) begin
         @(negedge clock);
         n++;
      end
      chk("idle_seen", 32'(idle === 1'b1), 1);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (2) @(negedge clock);
      chk("rst_cs", 32'(bus.uart_cs), 1);
      chk("rst_rd", 32'(bus.uart_rd), 1);
      chk("rst_wr", 32'(bus.uart_wr), 1);
      chk("rst_addr", 32'(bus.uart_addr), 0);
      chk("rst_wdata", 32'(bus.uart_wdata), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_ready", 32'(bus.s_ready), 1);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_terr", 32'(timeout_err), 0);
      reset = 1'b1;
      @(negedge clock);

      // single byte, UART idle
      polls = 0;
      push(8'h41);
      wait_wr(20);
      chk("w1_addr", 32'(bus.uart_addr), 2);
      chk("w1_data", 32'(bus.uart_wdata), 32'h41);
      chk("w1_level", 32'(level), 1);
      repeat (3) @(negedge clock);
      chk("hold_idle0", 32'(idle), 0);
      @(negedge clock);
      chk("hold_idle1", 32'(idle), 1);
      chk("w1_count", wq.size(), 1);
      chk("w1_q", 32'(wq[0]), 32'h41);
      chk("w1_polls", polls, 1);

      // UART busy for a long stretch
      wq.delete();
      busy = 1'b1;
      push(8'h55);
      repeat (10) @(negedge clock);
      #1 p0 = polls;
      repeat (20) @(negedge clock);
      #1 chk("poll_rate", polls - p0, 10);
      repeat (70) @(negedge clock);
      chk("busy_no_wr", wq.size(), 0);
      chk("busy_terr", 32'(timeout_err), 0);
      busy = 1'b0;
      wait_wr(20);
      chk("w2_data", 32'(bus.uart_wdata), 32'h55);
      wait_idle(20);
      chk("w2_count", wq.size(), 1);

      // fill to full, then drain in order
      wq.delete();
      busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("full_level", 32'(level), 16);
      chk("full_ready", 32'(bus.s_ready), 0);
      push(8'hAA);
      chk("full_ignore", 32'(level), 16);
      busy = 1'b0;
      wait_idle(400);
      chk("full_count", wq.size(), 16);
      for (int i = 0; i < 16; i++) chk("full_order", 32'(wq[i]), i);

      // reset in the middle of a write
      wq.delete();
      busy = 1'b1;
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      busy = 1'b0;
      wait_wr(20);
      chk("mr_level5", 32'(level), 5);
      #1 reset = 1'b0;
      #1;
      chk("mr_cs", 32'(bus.uart_cs), 1);
      chk("mr_wr", 32'(bus.uart_wr), 1);
      chk("mr_rd", 32'(bus.uart_rd), 1);
      chk("mr_level", 32'(level), 0);
      chk("mr_ready", 32'(bus.s_ready), 1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      wq.delete();
      polls = 0;
      repeat (40) @(negedge clock);
      chk("mr_polls", polls, 0);
      chk("mr_writes", wq.size(), 0);
      chk("mr_idle", 32'(idle), 1);

      // push coinciding with pop
      wq.delete();
      busy = 1'b1;
      for (int i = 0; i < 3; i++) push(8'h31 + 8'(i));
      busy = 1'b0;
      wait_wr(20);
      chk("pp_level_pre", 32'(level), 3);
      chk("pp_data", 32'(bus.uart_wdata), 32'h31);
      push(8'h34);
      chk("pp_level_post", 32'(level), 3);
      wait_idle(100);
      chk("pp_count", wq.size(), 4);
      for (int i = 0; i < 4; i++) chk("pp_order", 32'(wq[i]), 32'h31 + i);

`ifdef UART_TX_SEQ_TIMEOUT_EN
      // stuck busy: flush after TIMEOUT busy polls
      wq.delete();
      busy = 1'b1;
      polls = 0;
      for (int i = 0; i < 3; i++) push(8'h61 + 8'(i));
      begin
         int n = 0;
         while (timeout_err !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
         end
      end
      chk("to_err", 32'(timeout_err), 1);
      chk("to_polls", polls, 64);
      chk("to_level", 32'(level), 0);
      chk("to_idle", 32'(idle), 1);
      chk("to_writes", wq.size(), 0);
      busy = 1'b0;
      push(8'h7E);
      wait_idle(50);
      chk("to_count", wq.size(), 1);
      chk("to_data", 32'(wq[0]), 32'h7E);
      chk("to_sticky", 32'(timeout_err), 1);
`endif

      chk("protocol", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
